// File: rtl/jtag_scan_master.sv
// Host-side JTAG TAP driver: walks the TAP and performs complete IR/DR scans, capturing TDO.
// Optional feature macro: JTAG_SCAN_MASTER_RTI_DWELL_EN adds RTI_CYCLES idle TCKs after each scan.
module jtag_scan_master #(
    parameter int CLK_DIV    = 4,
    parameter int IR_W       = 10,
    parameter int MAX_DR     = 38,
    parameter int RTI_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              scan_ir,
    input  logic [5:0]        len,
    input  logic [MAX_DR-1:0] din,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [MAX_DR-1:0] dout,
    output logic              tck,
    output logic              tms,
    output logic              tdi,
    input  logic              tdo
);
    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]       IR_LEN   = 6'(IR_W);
    localparam logic [5:0]       MAX_LEN  = 6'(MAX_DR);
`ifdef JTAG_SCAN_MASTER_RTI_DWELL_EN
    localparam logic [5:0]       DWELL_LAST = 6'(RTI_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        TLR_WALK,
        PRE,
        SHIFT,
        EXIT_UPD,
        RTI,
`ifdef JTAG_SCAN_MASTER_RTI_DWELL_EN
        DWELL,
`endif
        FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              tck_q, tck_d;
    logic              tms_q, tms_d;
    logic              tdi_q, tdi_d;
    logic              error_q, error_d;
    logic              tap_known_q, tap_known_d;
    logic [MAX_DR-1:0] dout_q, dout_d;
    logic [MAX_DR-1:0] din_q, din_d;
    logic [MAX_DR-1:0] sh_q, sh_d;
    logic [5:0]        n_q, n_d;
    logic              ir_q, ir_d;

    logic running, accept, illegal, tck_rise, tck_fall;

    assign running  = (state_q != IDLE) && (state_q != FINISH);
    assign accept   = start && !running;
    assign illegal  = !scan_ir && ((len == 6'd0) || (len > MAX_LEN));
    assign tck_rise = running && !tck_q && (div_q == DIV_LAST);
    assign tck_fall = running && tck_q && (div_q == DIV_LAST);

    // TMS value presented for one TCK of the given step
    function automatic logic step_tms(state_t st, logic [5:0] cnt, logic ir, logic [5:0] n);
        case (st)
            TLR_WALK: step_tms = (cnt < 6'd5);
            PRE:      step_tms = ir ? (cnt < 6'd2) : (cnt == 6'd0);
            SHIFT:    step_tms = (cnt == n - 6'd1);
            EXIT_UPD: step_tms = 1'b1;
            default:  step_tms = 1'b0;
        endcase
    endfunction

    function automatic logic [MAX_DR-1:0] len_mask(logic [5:0] n);
        len_mask = '0;
        for (int i = 0; i < MAX_DR; i++) begin
            len_mask[i] = (i < int'(n));
        end
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 6'd0;
            div_q       <= '0;
            tck_q       <= 1'b0;
            tms_q       <= 1'b1;
            tdi_q       <= 1'b0;
            error_q     <= 1'b0;
            tap_known_q <= 1'b0;
            dout_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            tck_q       <= tck_d;
            tms_q       <= tms_d;
            tdi_q       <= tdi_d;
            error_q     <= error_d;
            tap_known_q <= tap_known_d;
            dout_q      <= dout_d;
        end
    end

    // Request operands and capture shift register; only meaningful while a scan runs
    always_ff @(posedge clk) begin
        din_q <= din_d;
        sh_q  <= sh_d;
        n_q   <= n_d;
        ir_q  <= ir_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (accept && !illegal) begin
                    state_d = tap_known_q ? PRE : TLR_WALK;
                    cnt_d   = 6'd0;
                end
            end
            default: begin
                if (tck_fall) begin
                    cnt_d = cnt_q + 6'd1;
                    case (state_q)
                        TLR_WALK: if (cnt_q == 6'd5) begin
                            state_d = PRE;
                            cnt_d   = 6'd0;
                        end
                        PRE: if (cnt_q == (ir_q ? 6'd3 : 6'd2)) begin
                            state_d = SHIFT;
                            cnt_d   = 6'd0;
                        end
                        SHIFT: if (cnt_q == n_q - 6'd1) begin
                            state_d = EXIT_UPD;
                            cnt_d   = 6'd0;
                        end
                        EXIT_UPD: begin
                            state_d = RTI;
                            cnt_d   = 6'd0;
                        end
`ifdef JTAG_SCAN_MASTER_RTI_DWELL_EN
                        RTI: begin
                            state_d = (RTI_CYCLES > 0) ? DWELL : FINISH;
                            cnt_d   = 6'd0;
                        end
                        DWELL: if (cnt_q == DWELL_LAST) begin
                            state_d = FINISH;
                            cnt_d   = 6'd0;
                        end
`else
                        RTI: begin
                            state_d = FINISH;
                            cnt_d   = 6'd0;
                        end
`endif
                        default: state_d = IDLE;
                    endcase
                end
            end
        endcase
    end

    always_comb begin
        div_d       = div_q;
        tck_d       = tck_q;
        tms_d       = tms_q;
        tdi_d       = tdi_q;
        dout_d      = dout_q;
        tap_known_d = tap_known_q;
        din_d       = din_q;
        sh_d        = sh_q;
        n_d         = n_q;
        ir_d        = ir_q;
        error_d     = accept && illegal;
        if (accept && !illegal) begin
            din_d = din;
            ir_d  = scan_ir;
            n_d   = scan_ir ? IR_LEN : len;
            sh_d  = '0;
            div_d = '0;
            tck_d = 1'b0;
        end else if (running) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (tck_rise) begin
                tck_d = 1'b1;
                if (state_q == SHIFT) sh_d[cnt_q] = tdo;
            end
            if (tck_fall) begin
                tck_d = 1'b0;
                if ((state_q == TLR_WALK) && (state_d == PRE)) tap_known_d = 1'b1;
                if (state_d == FINISH) dout_d = sh_q & len_mask(n_q);
            end
        end
        // New TMS/TDI are presented only at the start of a TCK low phase
        if ((accept && !illegal) || (tck_fall && (state_d != FINISH))) begin
            tms_d = step_tms(state_d, cnt_d, ir_d, n_d);
            tdi_d = (state_d == SHIFT) ? din_d[cnt_d] : 1'b0;
        end
    end

    always_comb begin
        busy = running;
        done = (state_q == FINISH);
    end

    assign error = error_q;
    assign dout  = dout_q;
    assign tck   = tck_q;
    assign tms   = tms_q;
    assign tdi   = tdi_q;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Bench for jtag_scan_master: behavioural TAP target plus scan-level reference expectations.
`timescale 1ns/1ps
module tb_jtag_scan_master;
    localparam int CLK_DIV    = 4;
    localparam int IR_W       = 10;
    localparam int MAX_DR     = 38;
    localparam int RTI_CYCLES = 2;
`ifdef JTAG_SCAN_MASTER_RTI_DWELL_EN
    localparam int DWELL = RTI_CYCLES;
`else
    localparam int DWELL = 0;
`endif
    localparam logic [37:0] IR_CAP = 38'h155;

    logic        clk = 1'b0;
    logic        reset, start, scan_ir;
    logic [5:0]  len;
    logic [37:0] din, dout;
    logic        busy, done, error, tck, tms, tdi;
    logic        tdo = 1'b0;

    jtag_scan_master #(
        .CLK_DIV(CLK_DIV), .IR_W(IR_W), .MAX_DR(MAX_DR), .RTI_CYCLES(RTI_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .scan_ir(scan_ir), .len(len), .din(din),
        .busy(busy), .done(done), .error(error), .dout(dout),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // ---------------- behavioural TAP target ----------------
    typedef enum int {
        TLR, RTI_S, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_t;

    function automatic tap_t tap_next(tap_t s, logic m);
        case (s)
            TLR:     return m ? TLR    : RTI_S;
            RTI_S:   return m ? SEL_DR : RTI_S;
            SEL_DR:  return m ? SEL_IR : CAP_DR;
            CAP_DR:  return m ? EX1_DR : SH_DR;
            SH_DR:   return m ? EX1_DR : SH_DR;
            EX1_DR:  return m ? UPD_DR : PAU_DR;
            PAU_DR:  return m ? EX2_DR : PAU_DR;
            EX2_DR:  return m ? UPD_DR : SH_DR;
            UPD_DR:  return m ? SEL_DR : RTI_S;
            SEL_IR:  return m ? TLR    : CAP_IR;
            CAP_IR:  return m ? EX1_IR : SH_IR;
            SH_IR:   return m ? EX1_IR : SH_IR;
            EX1_IR:  return m ? UPD_IR : PAU_IR;
            PAU_IR:  return m ? EX2_IR : PAU_IR;
            EX2_IR:  return m ? UPD_IR : SH_IR;
            default: return m ? SEL_DR : RTI_S;
        endcase
    endfunction

    tap_t        tap = PAU_IR;
    logic [37:0] dr_cap = '0, shv = '0, rx = '0, dr_rx = '0, ir_reg = '0;
    int          k = 0, dr_len = 0;
    int          tck_cnt = 0, done_cnt = 0, err_cnt = 0, glitch = 0;
    logic        tms_log[$];

    always @(posedge tck) begin
        tms_log.push_back(tms);
        tck_cnt++;
        case (tap)
            CAP_DR: begin shv = dr_cap; rx = '0; k = 0; end
            CAP_IR: begin shv = IR_CAP; rx = '0; k = 0; end
            SH_DR, SH_IR: begin
                if (k < 38) rx[k] = tdi;
                k++;
            end
            UPD_DR: begin dr_rx = rx; dr_len = k; end
            UPD_IR: ir_reg = rx;
            default: ;
        endcase
        tap = tap_next(tap, tms);
    end

    always @(negedge tck) tdo = ((tap == SH_DR || tap == SH_IR) && k < 38) ? shv[k] : 1'b0;

    always @(tms or tdi) if (tck === 1'b1 && reset === 1'b0) glitch++;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt++;
        if (error === 1'b1) err_cnt++;
    end

    // ---------------- scan-level reference ----------------
    function automatic logic [37:0] lmask(int n);
        logic [37:0] m;
        m = '0;
        for (int i = 0; i < 38; i++) if (i < n) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int exp_tcks(bit first, bit ir, int n);
        return (first ? 6 : 0) + (ir ? 4 : 3) + n + 2 + DWELL;
    endfunction

    function automatic logic [127:0] exp_trace(bit first, bit ir, int n);
        logic [127:0] t;
        int j;
        t = '0;
        j = 0;
        if (first) begin
            for (int i = 0; i < 5; i++) t[i] = 1'b1;
            j = 6;
        end
        t[j] = 1'b1;
        if (ir) begin
            t[j+1] = 1'b1;
            j += 4;
        end else begin
            j += 3;
        end
        t[j+n-1] = 1'b1;
        j += n;
        t[j] = 1'b1;
        return t;
    endfunction

    function automatic logic [127:0] trace_bits(int from);
        logic [127:0] t;
        t = '0;
        for (int i = from; i < tms_log.size() && (i - from) < 128; i++) t[i-from] = tms_log[i];
        return t;
    endfunction

    bit walk_due = 1'b1;

    task automatic launch(input bit ir, input logic [5:0] l, input logic [37:0] d);
        scan_ir = ir;
        len     = l;
        din     = d;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        scan_ir = 1'($urandom);
        len     = 6'($urandom);
        din     = 38'({$urandom, $urandom});
    endtask

    task automatic wait_done(input string nm);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk({nm, " done_seen"}, ok, 1'b1);
    endtask

    task automatic run_scan(input string nm, input bit ir, input logic [5:0] l,
                            input logic [37:0] d, input logic [37:0] cap,
                            input logic [37:0] exp_dout, input int exp_tck);
        int n, t0, l0, d0, e0;
        bit bad, first;
        logic [37:0] dout_prev;
        n         = ir ? IR_W : int'(l);
        bad       = !ir && (l == 6'd0 || int'(l) > MAX_DR);
        first     = walk_due;
        t0        = tck_cnt;
        l0        = tms_log.size();
        d0        = done_cnt;
        e0        = err_cnt;
        dout_prev = dout;
        dr_cap    = cap;
        launch(ir, l, d);
        if (bad) begin
            chk({nm, " error_pulse"}, error, 1'b1);
            chk({nm, " busy_low"}, busy, 1'b0);
            repeat (20) @(negedge clk);
            chk({nm, " error_count"}, err_cnt - e0, 1);
            chk({nm, " tck_edges"}, tck_cnt - t0, 0);
            chk({nm, " dout_held"}, dout, dout_prev);
        end else begin
            chk({nm, " busy_rise"}, busy, 1'b1);
            wait_done(nm);
            chk({nm, " busy_at_done"}, busy, 1'b0);
            chk({nm, " dout"}, dout, exp_dout);
            chk({nm, " tck_count"}, tck_cnt - t0, exp_tck);
            chk({nm, " tms_trace"}, trace_bits(l0), exp_trace(first, ir, n));
            if (ir) chk({nm, " target_ir"}, ir_reg[9:0], d[9:0]);
            else begin
                chk({nm, " target_dr"}, dr_rx, d & lmask(n));
                chk({nm, " target_dr_len"}, dr_len, n);
            end
            chk({nm, " tap_in_rti"}, tap, RTI_S);
            repeat (10) @(negedge clk);
            chk({nm, " done_once"}, done_cnt - d0, 1);
            chk({nm, " no_extra_tck"}, tck_cnt - t0, exp_tck);
            chk({nm, " dout_stable"}, dout, exp_dout);
            walk_due = 1'b0;
        end
    endtask

    typedef struct {
        bit          ir;
        logic [5:0]  l;
        logic [37:0] d;
        logic [37:0] cap;
        logic [37:0] exp_dout;
        int          exp_tck;
    } vec_t;

    vec_t        tbl[6];
    bit          r_ir;
    logic [5:0]  r_l;
    logic [37:0] r_d, r_c, r_e;
    int          r_n, r_t, pick, t0, d0, e0;
    bit          found;

    initial begin
        tbl[0] = '{1'b0, 6'd38, 38'h2A_5555_AAAA, 38'h12_3456_789A, 38'h12_3456_789A, 49 + DWELL};
        tbl[1] = '{1'b1, 6'd0,  38'h00E,          38'h0,            38'h155,          16 + DWELL};
        tbl[2] = '{1'b0, 6'd1,  38'h1,            38'h3F_FFFF_FFFF, 38'h1,            6 + DWELL};
        tbl[3] = '{1'b0, 6'd8,  38'hA5,           38'h3F_FFFF_FF5C, 38'h5C,           13 + DWELL};
        tbl[4] = '{1'b0, 6'd0,  38'h3,            38'h0,            38'h5C,           0};
        tbl[5] = '{1'b0, 6'd39, 38'h3,            38'h0,            38'h5C,           0};

        reset = 1'b1; start = 1'b0; scan_ir = 1'b0; len = 6'd0; din = '0;
        repeat (3) @(negedge clk);
        chk("reset tck", tck, 1'b0);
        chk("reset tms", tms, 1'b1);
        chk("reset tdi", tdi, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset error", error, 1'b0);
        chk("reset dout", dout, 38'h0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        chk("idle no tck edges", tck_cnt, 0);
        chk("idle tck low", tck, 1'b0);
        chk("idle busy", busy, 1'b0);

        for (int i = 0; i < 6; i++)
            run_scan($sformatf("vec%0d", i), tbl[i].ir, tbl[i].l, tbl[i].d, tbl[i].cap,
                     tbl[i].exp_dout, tbl[i].exp_tck);

        // back-to-back: second start in the done clk
        d0 = done_cnt;
        dr_cap = 38'h0A;
        launch(1'b0, 6'd5, 38'h15);
        wait_done("b2b first");
        chk("b2b first dout", dout, 38'h0A);
        t0 = tck_cnt;
        dr_cap = 38'h05;
        launch(1'b0, 6'd3, 38'h6);
        chk("b2b second busy", busy, 1'b1);
        wait_done("b2b second");
        chk("b2b second dout", dout, 38'h05);
        chk("b2b second target_dr", dr_rx, 38'h6);
        chk("b2b second tck_count", tck_cnt - t0, 3 + 3 + 2 + DWELL);
        repeat (10) @(negedge clk);
        chk("b2b done pulses", done_cnt - d0, 2);

        // start while busy is ignored, including an illegal one
        r_d = 38'h1234_5678 ^ 38'h3A5;
        r_c = 38'h2F_0F0F_0F0F;
        t0 = tck_cnt; e0 = err_cnt;
        dr_cap = r_c;
        launch(1'b0, 6'd12, r_d);
        repeat (20) @(negedge clk);
        scan_ir = 1'b0; len = 6'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        scan_ir = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        chk("busy_start dout", dout, r_c & lmask(12));
        chk("busy_start target_dr", dr_rx, r_d & lmask(12));
        chk("busy_start tck_count", tck_cnt - t0, 3 + 12 + 2 + DWELL);
        repeat (5) @(negedge clk);
        chk("busy_start no error", err_cnt - e0, 0);
        chk("busy_start idle", busy, 1'b0);

        // randomized scans against the scan-level reference
        for (int r = 0; r < 24; r++) begin
            r_ir = ($urandom_range(0, 3) == 0);
            pick = $urandom_range(0, 9);
            r_l  = (pick == 0) ? 6'd0 : (pick == 1) ? 6'($urandom_range(39, 63))
                                                    : 6'($urandom_range(1, 38));
            r_d  = 38'({$urandom, $urandom});
            r_c  = 38'({$urandom, $urandom});
            r_n  = r_ir ? IR_W : int'(r_l);
            r_e  = r_ir ? (IR_CAP & lmask(IR_W)) : (r_c & lmask(r_n));
            r_t  = exp_tcks(walk_due, r_ir, r_n);
            run_scan($sformatf("rand%0d", r), r_ir, r_l, r_d, r_c, r_e, r_t);
        end

        // reset asserted during shift bit 10
        dr_cap = 38'h3C_3C3C_3C3C;
        launch(1'b0, 6'd20, 38'h0F_FFFF);
        found = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (tap == SH_DR && k == 10) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("midscan reached bit 10", found, 1'b1);
        reset = 1'b1;
        #1;
        chk("midscan reset tck", tck, 1'b0);
        chk("midscan reset tms", tms, 1'b1);
        chk("midscan reset tdi", tdi, 1'b0);
        chk("midscan reset busy", busy, 1'b0);
        chk("midscan reset done", done, 1'b0);
        chk("midscan reset dout", dout, 38'h0);
        @(negedge clk);
        reset = 1'b0;
        walk_due = 1'b1;
        @(negedge clk);
        run_scan("post_reset", 1'b0, 6'd20, 38'h0A_BCDE, 38'h15_5AA5, 38'h15_5AA5 & lmask(20),
                 exp_tcks(1'b1, 1'b0, 20));

        chk("tms_tdi_stable_while_tck_high", glitch, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
